commit_queue: RTL

In-order commit queue for the vector unit: the parametrised successor to the single-bitmap commit tracker. It allocates instruction IDs in program order at dispatch and collects completion from `NrVFU` functional units. It retires up to `CommitWidth` instructions per cycle strictly in allocation order. Illegal instructions retire precisely: alone, and only from the head. The block sits between the decoder/dispatcher and the VFUs and the scalar-core completion interface.

---
 rtl/core_pkg.sv | 17 +
 rtl/commit_select.sv | 55 +++++
 rtl/commit_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared vector-unit definitions: commit queue sizing, ID type and per-entry state.
// Used by commit_queue and commit_select.
package core_pkg;

    localparam int unsigned CommitQueueDepth = 8;
    localparam int unsigned CommitWidth      = 2;
    localparam int unsigned CommitQueueIdW   = $clog2(CommitQueueDepth);

    typedef logic [CommitQueueIdW-1:0] cq_id_t;

    typedef struct packed {
        logic valid;
        logic done;
        logic illegal;
    } cq_entry_t;

endpackage

// File: rtl/commit_select.sv
// Combinational retirement selector: rotates the entry array by the head pointer and
// finds the in-order run of retirable entries, capped at CommitWidth.
module commit_select
    import core_pkg::cq_entry_t;
#(
    parameter int unsigned Depth       = 8,
    parameter int unsigned CommitWidth = 2,
    parameter int unsigned IdW         = $clog2(Depth),
    parameter int unsigned RunW        = $clog2(CommitWidth + 1)
) (
    input  cq_entry_t [Depth-1:0]           entries_i,
    input  logic [IdW-1:0]                  head_i,
    output logic [CommitWidth-1:0]          commit_valid_o,
    output logic [CommitWidth-1:0][IdW-1:0] commit_id_o,
    output logic                            commit_illegal_o,
    output logic [RunW-1:0]                 num_retire_o
);

    cq_entry_t [CommitWidth-1:0]  window;
    logic [CommitWidth-1:0][IdW-1:0] slot_id;
    logic                         run_open;

    always_comb begin
        for (int i = 0; i < CommitWidth; i++) begin
            slot_id[i] = IdW'((int'(head_i) + i) % Depth);
            window[i]  = entries_i[slot_id[i]];
        end
    end

    // An illegal head retires alone; an illegal entry further back closes the run.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        commit_valid_o   = '0;
        commit_id_o      = '0;
        commit_illegal_o = 1'b0;
        num_retire_o     = '0;
        run_open         = 1'b1;
        for (int i = 0; i < CommitWidth; i++) begin
            if (i == 0 && window[0].valid && window[0].illegal) begin
                commit_valid_o[0] = 1'b1;
                commit_illegal_o  = 1'b1;
                run_open          = 1'b0;
            end else if (run_open && window[i].valid && window[i].done && !window[i].illegal) begin
                commit_valid_o[i] = 1'b1;
            end else begin
                run_open = 1'b0;
            end
            if (commit_valid_o[i]) begin
                commit_id_o[i] = slot_id[i];
                num_retire_o   = num_retire_o + RunW'(1);
            end
        end
    end

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue: allocates IDs at dispatch, collects VFU completions, retires
// up to CommitWidth per cycle in order. Optional flush port: COMMIT_QUEUE_FLUSH_EN.
module commit_queue
    import core_pkg::cq_entry_t;
#(
    parameter int unsigned NrVFU       = 4,
    parameter int unsigned Depth       = core_pkg::CommitQueueDepth,
    parameter int unsigned CommitWidth = core_pkg::CommitWidth,
    parameter int unsigned IdW         = $clog2(Depth),
    parameter int unsigned CntW        = $clog2(Depth + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
`ifdef COMMIT_QUEUE_FLUSH_EN
    input  logic                            flush_i,
`endif
    input  logic                            alloc_valid_i,
    input  logic                            alloc_illegal_i,
    output logic                            alloc_ready_o,
    output logic [IdW-1:0]                  alloc_id_o,
    input  logic [NrVFU-1:0]                vfu_done_i,
    input  logic [NrVFU-1:0][IdW-1:0]       vfu_done_id_i,
    output logic [CommitWidth-1:0]          commit_valid_o,
    output logic [CommitWidth-1:0][IdW-1:0] commit_id_o,
    output logic                            commit_illegal_o,
    output logic [IdW-1:0]                  head_id_o,
    output logic [CntW-1:0]                 count_o,
    output logic                            empty_o
);

    localparam int unsigned RunW = $clog2(CommitWidth + 1);

    cq_entry_t [Depth-1:0]           entries_q, entries_d;
    logic [IdW-1:0]                  head_q, head_d;
    logic [IdW-1:0]                  tail_q, tail_d;
    logic [CntW-1:0]                 count_q, count_d;

    logic [CommitWidth-1:0]          sel_valid;
    logic [CommitWidth-1:0][IdW-1:0] sel_id;
    logic                            sel_illegal;
    logic [RunW-1:0]                 num_retire;
    logic                            alloc_fire;

    commit_select #(
        .Depth       (Depth),
        .CommitWidth (CommitWidth),
        .IdW         (IdW),
        .RunW        (RunW)
    ) u_commit_select (
        .entries_i        (entries_q),
        .head_i           (head_q),
        .commit_valid_o   (sel_valid),
        .commit_id_o      (sel_id),
        .commit_illegal_o (sel_illegal),
        .num_retire_o     (num_retire)
    );

    assign alloc_ready_o = (count_q < CntW'(Depth));
    assign alloc_id_o    = tail_q;
    assign head_id_o     = head_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign commit_id_o   = sel_id;

`ifdef COMMIT_QUEUE_FLUSH_EN
    assign commit_valid_o   = flush_i ? '0 : sel_valid;
    assign commit_illegal_o = sel_illegal && !flush_i;
`else
    assign commit_valid_o   = sel_valid;
    assign commit_illegal_o = sel_illegal;
`endif

    always_comb begin
        entries_d = entries_q;
        for (int k = 0; k < NrVFU; k++) begin
            if (vfu_done_i[k] && entries_q[vfu_done_id_i[k]].valid) begin
                entries_d[vfu_done_id_i[k]].done = 1'b1;
            end
        end
        for (int i = 0; i < CommitWidth; i++) begin
            if (sel_valid[i]) begin
                entries_d[sel_id[i]] = '0;
            end
        end
        // The tail slot is free whenever allocation is allowed, so it never collides with a retiring slot.
        if (alloc_fire) begin
            entries_d[tail_q] = '{valid: 1'b1, done: alloc_illegal_i, illegal: alloc_illegal_i};
        end
        head_d  = head_q + IdW'(num_retire);
        tail_d  = tail_q + IdW'(alloc_fire);
        count_d = count_q + CntW'(alloc_fire) - CntW'(num_retire);
`ifdef COMMIT_QUEUE_FLUSH_EN
        if (flush_i) begin
            entries_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the entry flags are reset too, not only the pointers: stale valid/done bits would retire phantom IDs.
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge state.
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

`ifndef SYNTHESIS
    for (genvar k = 0; k < NrVFU; k++) begin : g_done_chk
        a_done_targets_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
            vfu_done_i[k] |-> entries_q[vfu_done_id_i[k]].valid);
    end
`endif

endmodule
